// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: fetch/decode/execute/memory sequencing with a memory-wait timeout trap.
// Define MULTICYCLE_CONTROL_IRQ_EN to redirect FETCH entry into an interrupt TRAP with a one-hot acknowledge.
module multicycle_control #(
    parameter int N_IRQ       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [5:0]       op_code,
    input  logic             Z,
    input  logic             supervisor,
    input  logic [N_IRQ-1:0] irq,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IR_LD,
    output logic             PC_LD,
    output logic [5:0]       ALUFN,
    output logic             ASEL,
    output logic             BSEL,
    output logic             MOE,
    output logic             MWR,
    output logic             RA2SEL,
    output logic             WASEL,
    output logic             WERF,
    output logic [2:0]       PCSEL,
    output logic [1:0]       WDSEL,
    output logic [N_IRQ-1:0] irq_ack
);

    // state    | meaning
    // S_FETCH  | instruction read, IR_LD on mem_ready
    // S_DECODE | latch opcode, pick EXEC or MEM
    // S_EXEC   | one-cycle ALU / branch / JMP / ILLOP write-back
    // S_MEM    | LD/ST data access
    // S_TRAP   | bus-error or interrupt vector, one cycle
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_TRAP} state_t;

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;
    localparam logic [5:0] FN_ADD = 6'b010000;
    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    state_t           w_state_d;
    logic [5:0]       r_op;
    logic [7:0]       r_cnt;
    logic [N_IRQ-1:0] r_irq_ack;
    logic [N_IRQ-1:0] w_ack_d;
    logic             w_mem_req;
    logic             w_mwr;
    logic             w_wait;
    logic             w_timeout;
    logic             w_alu_ok;
    logic             w_is_alu;
    logic [5:0]       w_alufn;

    always_comb begin
        w_alu_ok = 1'b1;
        w_alufn  = '0;
        case (r_op[3:0])
            4'h0:    w_alufn = 6'b010000;
            4'h1:    w_alufn = 6'b010001;
            4'h4:    w_alufn = 6'b000011;
            4'h5:    w_alufn = 6'b000101;
            4'h6:    w_alufn = 6'b000111;
            4'h8:    w_alufn = 6'b101000;
            4'h9:    w_alufn = 6'b101110;
            4'hA:    w_alufn = 6'b100110;
            4'hB:    w_alufn = 6'b101001;
            4'hC:    w_alufn = 6'b110000;
            4'hD:    w_alufn = 6'b110001;
            4'hE:    w_alufn = 6'b110011;
            default: w_alu_ok = 1'b0;
        endcase
    end

    assign w_is_alu  = r_op[5] & w_alu_ok;
    assign w_wait    = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_timeout = w_wait && (r_cnt == CNT_LAST);

    always_comb begin
        w_next    = r_state;
        w_mem_req = 1'b0;
        w_mwr     = 1'b0;
        IR_LD     = 1'b0;
        PC_LD     = 1'b0;
        ALUFN     = '0;
        BSEL      = 1'b0;
        MOE       = 1'b0;
        RA2SEL    = 1'b0;
        WASEL     = 1'b0;
        WERF      = 1'b0;
        PCSEL     = 3'b000;
        WDSEL     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                MOE       = 1'b1;
                if (mem_ready) begin
                    IR_LD  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: begin
                w_next = ((op_code == OP_LD) || (op_code == OP_ST)) ? S_MEM : S_EXEC;
            end
            S_EXEC: begin
                PC_LD  = 1'b1;
                WERF   = 1'b1;
                w_next = S_FETCH;
                if (w_is_alu) begin
                    ALUFN = w_alufn;
                    BSEL  = r_op[4];
                    WDSEL = 2'b01;
                end else begin
                    case (r_op)
                        OP_JMP:  PCSEL = 3'b010;
                        OP_BEQ:  PCSEL = Z ? 3'b001 : 3'b000;
                        OP_BNE:  PCSEL = Z ? 3'b000 : 3'b001;
                        default: begin
                            PCSEL = 3'b011;
                            WASEL = 1'b1;
                        end
                    endcase
                end
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                BSEL      = 1'b1;
                ALUFN     = FN_ADD;
                if (r_op == OP_LD) begin
                    MOE = 1'b1;
                end else begin
                    RA2SEL = 1'b1;
                    w_mwr  = 1'b1;
                end
                if (mem_ready) begin
                    PC_LD  = 1'b1;
                    w_next = S_FETCH;
                    if (r_op == OP_LD) begin
                        WDSEL = 2'b10;
                        WERF  = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_TRAP: begin
                PCSEL  = 3'b100;
                WASEL  = 1'b1;
                WERF   = 1'b1;
                PC_LD  = 1'b1;
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

`ifdef MULTICYCLE_CONTROL_IRQ_EN
    logic w_irq_take;
    assign w_irq_take = (w_next == S_FETCH) && (r_state != S_FETCH) && !supervisor && (|irq);
    assign w_state_d  = w_irq_take ? S_TRAP : w_next;
    assign w_ack_d    = w_irq_take ? (irq & (~irq + N_IRQ'(1))) : '0;
`else
    logic w_unused_irq;
    assign w_unused_irq = ^{supervisor, irq};
    assign w_state_d    = w_next;
    assign w_ack_d      = '0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_cnt     <= '0;
            r_irq_ack <= '0;
        end else begin
            r_state   <= w_state_d;
            r_irq_ack <= w_ack_d;
            if (r_state == S_DECODE) begin
                r_op <= op_code;
            end
            if (w_state_d != r_state) begin
                r_cnt <= '0;
            end else if (w_wait) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Bus strobes are gated by reset so an access in flight is dropped immediately.
    assign mem_req = w_mem_req & n_rst;
    assign MWR     = w_mwr & n_rst;
    assign ASEL    = 1'b0;
    assign irq_ack = r_irq_ack;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected control vectors are queued per step and compared mid-cycle.
module tb_multicycle_control;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic [5:0]   op_code = '0;
    logic         Z = 1'b0;
    logic         supervisor = 1'b0;
    logic [N-1:0] irq = '0;
    logic         mem_ready = 1'b0;
    logic         mem_req, IR_LD, PC_LD, ASEL, BSEL, MOE, MWR, RA2SEL, WASEL, WERF;
    logic [5:0]   ALUFN;
    logic [2:0]   PCSEL;
    logic [1:0]   WDSEL;
    logic [N-1:0] irq_ack;

    multicycle_control #(.N_IRQ(N), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .n_rst(n_rst), .op_code(op_code), .Z(Z), .supervisor(supervisor),
        .irq(irq), .mem_ready(mem_ready), .mem_req(mem_req), .IR_LD(IR_LD), .PC_LD(PC_LD),
        .ALUFN(ALUFN), .ASEL(ASEL), .BSEL(BSEL), .MOE(MOE), .MWR(MWR), .RA2SEL(RA2SEL),
        .WASEL(WASEL), .WERF(WERF), .PCSEL(PCSEL), .WDSEL(WDSEL), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [20:0]  ctl;
        logic [N-1:0] ack;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [5:0] ADD = 6'b010000;

    function automatic logic [20:0] V(input logic mreq, irld, pcld, input logic [5:0] fn,
                                      input logic bsel, moe, mwr, ra2, wasel, werf,
                                      input logic [2:0] pcsel, input logic [1:0] wdsel);
        return {mreq, irld, pcld, fn, 1'b0, bsel, moe, mwr, ra2, wasel, werf, pcsel, wdsel};
    endfunction

    function automatic logic [20:0] obs_vec();
        return {mem_req, IR_LD, PC_LD, ALUFN, ASEL, BSEL, MOE, MWR, RA2SEL, WASEL, WERF, PCSEL, WDSEL};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic [20:0] ctl, input logic [N-1:0] ack);
        exp_t e;
        e.tag = tag;
        e.ctl = ctl;
        e.ack = ack;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, ":ctl"}, 32'(obs_vec()), 32'(e.ctl));
        chk({e.tag, ":ack"}, 32'(irq_ack), 32'(e.ack));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input logic z,
                             input logic [20:0] exec_ctl);
        logic [20:0] f_rdy;
        f_rdy = V(1, 1, 0, 6'd0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b00);
        mem_ready = 1'b1;
        op_code   = op;
        Z         = z;
        step({tag, "_fetch"}, f_rdy, '0);
        mem_ready = 1'b0;
        step({tag, "_dec"}, 21'd0, '0);
        step(tag, exec_ctl, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [20:0] f_wait, trap_v, ld_wait, ld_done, st_wait;
        f_wait  = V(1, 0, 0, 6'd0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b00);
        trap_v  = V(0, 0, 1, 6'd0, 0, 0, 0, 0, 1, 1, 3'b100, 2'b00);
        ld_wait = V(1, 0, 0, ADD, 1, 1, 0, 0, 0, 0, 3'b000, 2'b00);
        ld_done = V(1, 0, 1, ADD, 1, 1, 0, 0, 0, 1, 3'b000, 2'b10);
        st_wait = V(1, 0, 0, ADD, 1, 0, 1, 1, 0, 0, 3'b000, 2'b00);

        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mwr", 32'(MWR), 32'd0);
        chk("rst_irq_ack", 32'(irq_ack), 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        run_instr("add", 6'h20, 0, V(0, 0, 1, 6'b010000, 0, 0, 0, 0, 0, 1, 3'b000, 2'b01));
        step("add_back_fetch", f_wait, '0);

        run_instr("sub_c", 6'h31, 0, V(0, 0, 1, 6'b010001, 1, 0, 0, 0, 0, 1, 3'b000, 2'b01));
        run_instr("xnor", 6'h2B, 0, V(0, 0, 1, 6'b101001, 0, 0, 0, 0, 0, 1, 3'b000, 2'b01));
        run_instr("sra_c", 6'h3E, 1, V(0, 0, 1, 6'b110011, 1, 0, 0, 0, 0, 1, 3'b000, 2'b01));
        run_instr("cmple", 6'h26, 0, V(0, 0, 1, 6'b000111, 0, 0, 0, 0, 0, 1, 3'b000, 2'b01));
        run_instr("or_c", 6'h39, 0, V(0, 0, 1, 6'b101110, 1, 0, 0, 0, 0, 1, 3'b000, 2'b01));
        run_instr("beq_t", 6'h1C, 1, V(0, 0, 1, 6'd0, 0, 0, 0, 0, 0, 1, 3'b001, 2'b00));
        run_instr("beq_n", 6'h1C, 0, V(0, 0, 1, 6'd0, 0, 0, 0, 0, 0, 1, 3'b000, 2'b00));
        run_instr("bne_t", 6'h1D, 0, V(0, 0, 1, 6'd0, 0, 0, 0, 0, 0, 1, 3'b001, 2'b00));
        run_instr("bne_n", 6'h1D, 1, V(0, 0, 1, 6'd0, 0, 0, 0, 0, 0, 1, 3'b000, 2'b00));
        run_instr("jmp", 6'h1B, 0, V(0, 0, 1, 6'd0, 0, 0, 0, 0, 0, 1, 3'b010, 2'b00));
        run_instr("illop_3f", 6'h3F, 0, V(0, 0, 1, 6'd0, 0, 0, 0, 0, 1, 1, 3'b011, 2'b00));
        run_instr("illop_22", 6'h22, 0, V(0, 0, 1, 6'd0, 0, 0, 0, 0, 1, 1, 3'b011, 2'b00));

        mem_ready = 1'b1;
        op_code   = 6'h18;
        step("ld_fetch", V(1, 1, 0, 6'd0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b00), '0);
        mem_ready = 1'b0;
        step("ld_dec", 21'd0, '0);
        for (int i = 0; i < 5; i++) step($sformatf("ld_wait%0d", i), ld_wait, '0);
        mem_ready = 1'b1;
        step("ld_done", ld_done, '0);
        mem_ready = 1'b0;
        step("ld_back_fetch", f_wait, '0);

        mem_ready = 1'b1;
        op_code   = 6'h18;
        step("ldlim_fetch", V(1, 1, 0, 6'd0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b00), '0);
        mem_ready = 1'b0;
        step("ldlim_dec", 21'd0, '0);
        for (int i = 0; i < 14; i++) step($sformatf("ldlim_wait%0d", i), ld_wait, '0);
        mem_ready = 1'b1;
        step("ldlim_done", ld_done, '0);
        mem_ready = 1'b0;
        step("ldlim_back_fetch", f_wait, '0);

        mem_ready = 1'b1;
        op_code   = 6'h19;
        step("st_fetch", V(1, 1, 0, 6'd0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b00), '0);
        mem_ready = 1'b0;
        step("st_dec", 21'd0, '0);
        for (int i = 0; i < 15; i++) step($sformatf("st_wait%0d", i), st_wait, '0);
        step("st_timeout_trap", trap_v, '0);
        step("st_after_trap", f_wait, '0);

        mem_ready = 1'b1;
        op_code   = 6'h19;
        step("strst_fetch", V(1, 1, 0, 6'd0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b00), '0);
        mem_ready = 1'b0;
        step("strst_dec", 21'd0, '0);
        step("strst_mem", st_wait, '0);
        #2;
        n_rst = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_mwr", 32'(MWR), 32'd0);
        chk("midrst_werf", 32'(WERF), 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        step("post_rst_fetch", f_wait, '0);

        irq        = 4'b0110;
        supervisor = 1'b1;
        run_instr("sup_add", 6'h20, 0, V(0, 0, 1, 6'b010000, 0, 0, 0, 0, 0, 1, 3'b000, 2'b01));
        step("sup_no_trap", f_wait, '0);

        supervisor = 1'b0;
        run_instr("irq_add", 6'h20, 0, V(0, 0, 1, 6'b010000, 0, 0, 0, 0, 0, 1, 3'b000, 2'b01));
        irq = '0;
`ifdef MULTICYCLE_CONTROL_IRQ_EN
        step("irq_trap", trap_v, 4'b0010);
        step("irq_after_trap", f_wait, '0);
`else
        step("irq_ignored", f_wait, '0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter N_IRQ, default 4: number of interrupt request lines (1..8); line 0 has the highest priority.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum mem_ready wait cycles before a bus-error trap (1..255).
REQ-003 clk  in  1  single clock for all state; every flop rises on posedge clk.
REQ-004 n_rst  in  1  asynchronous, active-low reset.
REQ-005 op_code  in  6  opcode field of the current IR; sampled only in DECODE.
REQ-006 Z  in  1  register-A-is-zero flag used for BEQ/BNE.
REQ-007 supervisor  in  1  PC[31] supervisor bit; 1 blocks interrupts.
REQ-008 irq  in  N_IRQ  level interrupt requests.
REQ-009 mem_ready  in  1  memory handshake completion for the current mem_req.
REQ-010 mem_req  out  1  memory access request; held until mem_ready or timeout.
REQ-011 IR_LD, PC_LD  out  1 each  load strobes for the instruction and PC registers.
REQ-012 ALUFN  out  6; ASEL, BSEL, MOE, MWR, RA2SEL, WASEL, WERF  out  1 each; PCSEL  out  3; WDSEL  out  2  datapath controls.
REQ-013 irq_ack  out  N_IRQ  one-hot acknowledge, one-cycle pulse.

Function
REQ-014 FSM states: FETCH, DECODE, EXEC, MEM, TRAP; every state other than FETCH returns to FETCH.
REQ-015 FETCH: mem_req=1, MOE=1; on mem_ready, IR_LD=1 and the FSM goes to DECODE; otherwise it stays in FETCH.
REQ-016 DECODE: latch op_code into an internal register; with no datapath strobes active, go to EXEC, or to MEM for LD (0x18) or ST (0x19).
REQ-017 ALU ops: 0x20,0x21,0x24-0x26,0x28-0x2E decode with BSEL=0; 0x30,0x31,0x34-0x36,0x38-0x3E decode with BSEL=1; all use WDSEL=01, WERF=1, PCSEL=000, WASEL=0, RA2SEL=0.
REQ-018 ALUFN map: ADD 010000, SUB 010001, CMPEQ 000011, CMPLT 000101, CMPLE 000111, AND 101000, OR 101110, XOR 100110, XNOR 101001, SHL 110000, SHR 110001, SRA 110011.
REQ-019 Low opcode nibble selects the operation: 0 ADD, 1 SUB, 4 CMPEQ, 5 CMPLT, 6 CMPLE, 8 AND, 9 OR, A XOR, B XNOR, C SHL, D SHR, E SRA.
REQ-020 EXEC: one cycle; assert PC_LD=1, WERF per the instruction, then go to FETCH.
REQ-021 JMP 0x1B: PCSEL=010, WDSEL=00, WERF=1.
REQ-022 BEQ 0x1C takes PCSEL=001 when Z=1; BNE 0x1D takes PCSEL=001 when Z=0; a not-taken branch uses PCSEL=000; both write PC+4 (WDSEL=00, WERF=1).
REQ-023 MEM: mem_req=1, BSEL=1, ALUFN=ADD.
REQ-024 MEM for LD: MOE=1; on mem_ready, WDSEL=10, WERF=1, PC_LD=1.
REQ-025 MEM for ST: RA2SEL=1, MWR=1; on mem_ready, PC_LD=1 with WERF=0.
REQ-026 Any other opcode (including 0x22, 0x23, 0x27, 0x2F, 0x37, 0x3F): EXEC performs an ILLOP trap with PCSEL=011, WASEL=1, WDSEL=00, WERF=1, PC_LD=1.
REQ-027 A cycle counter runs in FETCH/MEM while mem_req=1 and mem_ready=0; on reaching MEM_TIMEOUT, go to TRAP, drop mem_req and MWR, and write no register.
REQ-028 TRAP: PCSEL=100, WASEL=1, WDSEL=00, WERF=1, PC_LD=1, one cycle, then FETCH.
REQ-029 The counter clears on every state change; mem_ready arriving in the same cycle as the limit is reached wins (normal completion).
REQ-030 Outputs are Moore/decode-registered; in any state, every control not listed for that state is 0.

Reset
REQ-031 While n_rst=0: state=FETCH, counter=0, latched opcode=0, irq_ack=0.
REQ-032 Out of reset, every output is 0 except mem_req=1 and MOE=1 (FETCH).
REQ-033 Reset asserted mid-MEM aborts the access: mem_req and MWR fall asynchronously, and no write-back occurs.

Configuration
REQ-034 Macro MULTICYCLE_CONTROL_IRQ_EN.
REQ-035 With the macro defined: at FETCH entry, if supervisor=0 and any irq bit is 1, go to TRAP instead of starting a fetch.
REQ-036 In that interrupt trap, PCSEL=100 and irq_ack is pulsed for the lowest-index active line.
REQ-037 Without the macro: irq is ignored, irq_ack is constant 0, and TRAP is reachable only by timeout.

Verification
REQ-038 Reset release, then mem_ready=1 for one cycle with op 0x20 -> IR_LD in cycle 1, then EXEC with ALUFN=010000, WERF=1, PC_LD=1; the FSM is back in FETCH 3 cycles after reset.
REQ-039 Op 0x1C with Z=1 -> PCSEL=001; op 0x1C with Z=0 -> PCSEL=000; both give WDSEL=00.
REQ-040 LD (0x18) with mem_ready delayed 5 cycles -> mem_req held 5 cycles, then WDSEL=10, WERF=1.
REQ-041 ST with mem_ready never asserted, MEM_TIMEOUT=15 -> TRAP after 15 wait cycles with PCSEL=100 and MWR=0.
REQ-042 Op 0x3F -> PCSEL=011, WASEL=1, WERF=1.
REQ-043 With IRQ enabled, irq=4'b0110 and supervisor=0 -> TRAP with irq_ack=4'b0010; with supervisor=1 -> normal fetch and no ack.
